// File: rtl/op_acc_sat.sv
// op_acc_sat: frame accumulator placed after the op_mult multiplier.
//   Accepts {in_data, in_ov} product beats on a valid/ready handshake and sums
//   LEN beats per frame into an ACC_W-bit accumulator. The accumulator either
//   clamps (SATURATE=1) or wraps (SATURATE=0) on overflow. It emits one
//   {out_data, out_ov, out_count} result per frame.
// Optional feature: define OP_ACC_FLUSH_EN to add the `flush` input, which
//   closes a non-empty frame early.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready depends only on state
//   in_data [2*N-1:0]    product beat
//   in_ov                multiplier overflow flag for this beat
//   flush                (OP_ACC_FLUSH_EN only) close the frame early
//   out_valid/out_ready  output handshake
//   out_data [ACC_W-1:0] frame sum
//   out_ov               sticky overflow flag for the frame
//   out_count            number of beats summed into out_data
module op_acc_sat #(
  parameter int N        = 16,
  parameter int ACC_W    = 2*N+8,
  parameter int LEN      = 8,
  parameter int SATURATE = 1,
  parameter int SIGNED   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*N-1:0]           in_data,
  input  logic                     in_ov,
`ifdef OP_ACC_FLUSH_EN
  input  logic                     flush,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_ov,
  output logic [$clog2(LEN+1)-1:0] out_count
);

  localparam int CW = $clog2(LEN+1);

  typedef enum logic {S_ACCUM, S_OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sat_val;
  logic [ACC_W-1:0] add_val;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [CW-1:0]    cnt_inc;
  logic             take;
  logic             close;

  // The adder is one bit wider than the accumulator. In signed mode, the
  // extra bit is the true sign of the result. It selects the clamp direction.
  always_comb begin
    if (SIGNED != 0) begin
      ext     = ACC_W'($signed(in_data));
      sum     = {acc_q[ACC_W-1], acc_q} + {ext[ACC_W-1], ext};
      ovf     = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ext     = ACC_W'(in_data);
      sum     = {1'b0, acc_q} + {1'b0, ext};
      ovf     = sum[ACC_W];
      sat_val = '1;
    end
    add_val = (ovf && (SATURATE != 0)) ? sat_val : sum[ACC_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    take     = 1'b0;
    close    = 1'b0;
    cnt_inc  = cnt_q + CW'(1);
    unique case (state_q)
      S_ACCUM: begin
        take = in_valid;
        if (take) begin
          acc_d    = add_val;
          cnt_d    = cnt_inc;
          sticky_d = sticky_q | ovf | in_ov;
          close    = (cnt_inc == CW'(LEN));
        end
`ifdef OP_ACC_FLUSH_EN
        // A flush on an empty frame with no beat in the same cycle is ignored.
        if (flush && (take || (cnt_q != '0))) close = 1'b1;
`endif
        if (close) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // The result registers double as the accumulator state. They stay frozen
  // in S_OUTPUT until the downstream stage accepts the result.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign out_data  = acc_q;
  assign out_ov    = sticky_q;
  assign out_count = cnt_q;

endmodule
